// File: rtl/nes_input_pkg.sv
// nes_input_pkg: shared joypad state encoding, button indices and timeout default
package nes_input_pkg;
    typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_DONE} joy_state_e;
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int TIMEOUT_DEFAULT = 2400000;
    function automatic logic [7:0] suppress_opposing(input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (d[BTN_UP] && d[BTN_DOWN]) begin
            r[BTN_UP]   = 1'b0;
            r[BTN_DOWN] = 1'b0;
        end
        if (d[BTN_LEFT] && d[BTN_RIGHT]) begin
            r[BTN_LEFT]  = 1'b0;
            r[BTN_RIGHT] = 1'b0;
        end
        return r;
    endfunction
endpackage

// File: rtl/nes_pad_watchdog.sv
// nes_pad_watchdog: saturating 24-bit idle counter, expired once LIMIT cycles pass without clear
module nes_pad_watchdog #(
    parameter int LIMIT = 2400000
) (
    input  logic clk24,
    input  logic rst,
    input  logic clear,
    output logic expired
);
    localparam logic [23:0] LIM = 24'(LIMIT);
    logic [23:0] cnt_q, cnt_d;
    always_comb begin
        expired = cnt_q == LIM;
        cnt_d   = clear ? 24'd0 : expired ? cnt_q : cnt_q + 24'd1;
    end
    always_ff @(posedge clk24 or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
endmodule

// File: rtl/nes_joypad_port.sv
// nes_joypad_port: USB gamepad report to NES $4016 serial joypad protocol
module nes_joypad_port
    import nes_input_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int MASK_OPPOSING  = 1
) (
    input  logic       clk24,
    input  logic       rst,
    input  logic       usb_gamepad_ena,
    input  logic [7:0] usb_gamepad_data,
    input  logic       jp_wr,
    input  logic       jp_wdata,
    input  logic       jp_rd,
    output logic       jp_dout,
    output logic       pad_connected
);
    joy_state_e state_q, state_d;
    logic [7:0] latch_q, latch_d, shreg_q, shreg_d;
    logic [3:0] cnt_q, cnt_d;
    logic       strobe_q, strobe_d, conn_q, conn_d, expired, shift;

    nes_pad_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk24   (clk24),
        .rst     (rst),
        .clear   (usb_gamepad_ena),
        .expired (expired)
    );

    always_comb begin
        latch_d  = usb_gamepad_ena ? (MASK_OPPOSING != 0 ? suppress_opposing(usb_gamepad_data) : usb_gamepad_data)
                                   : expired ? 8'h00 : latch_q;
        conn_d   = usb_gamepad_ena ? 1'b1 : expired ? 1'b0 : conn_q;
        strobe_d = jp_wr ? jp_wdata : strobe_q;
        // a write in the same cycle as a read wins; the read does not shift
        shift    = jp_rd & ~jp_wr;
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_LOAD: begin
                shreg_d = latch_q;
                cnt_d   = 4'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: if (shift) begin
                shreg_d = {1'b1, shreg_q[7:1]};
                cnt_d   = cnt_q + 4'd1;
                state_d = cnt_q == 4'd7 ? ST_DONE : ST_SHIFT;
            end
            default: if (shift) shreg_d = 8'hFF;
        endcase
        if (strobe_d) state_d = ST_LOAD;
        jp_dout       = state_q == ST_LOAD ? latch_q[0] : shreg_q[0];
        pad_connected = conn_q;
    end

    always_ff @(posedge clk24 or negedge rst)
        if (!rst) begin
            state_q  <= ST_DONE;
            latch_q  <= 8'h00;
            shreg_q  <= 8'hFF;
            cnt_q    <= 4'd8;
            strobe_q <= 1'b0;
            conn_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            latch_q  <= latch_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            conn_q   <= conn_d;
        end
endmodule

// File: tb/tb_nes_joypad_port.sv
// tb_nes_joypad_port: scoreboard bench driving a masked and an unmasked port in parallel
module tb_nes_joypad_port;
    logic       clk24 = 1'b0;
    logic       rst = 1'b0;
    logic       usb_gamepad_ena = 1'b0;
    logic [7:0] usb_gamepad_data = 8'h00;
    logic       jp_wr = 1'b0, jp_wdata = 1'b0, jp_rd = 1'b0;
    logic       dout_m, dout_n, pc_m, pc_n;
    int         checks = 0, errors = 0;
    logic [1:0] exp_q [$];

    always #5 clk24 = ~clk24;

    nes_joypad_port #(.TIMEOUT_CYCLES(100), .MASK_OPPOSING(1)) dut_m (
        .clk24(clk24), .rst(rst), .usb_gamepad_ena(usb_gamepad_ena), .usb_gamepad_data(usb_gamepad_data),
        .jp_wr(jp_wr), .jp_wdata(jp_wdata), .jp_rd(jp_rd), .jp_dout(dout_m), .pad_connected(pc_m)
    );
    nes_joypad_port #(.TIMEOUT_CYCLES(100), .MASK_OPPOSING(0)) dut_n (
        .clk24(clk24), .rst(rst), .usb_gamepad_ena(usb_gamepad_ena), .usb_gamepad_data(usb_gamepad_data),
        .jp_wr(jp_wr), .jp_wdata(jp_wdata), .jp_rd(jp_rd), .jp_dout(dout_n), .pad_connected(pc_n)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk24);
    endtask

    function automatic logic [7:0] model_mask(input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (d[4] && d[5]) r[5:4] = 2'b00;
        if (d[6] && d[7]) r[7:6] = 2'b00;
        return r;
    endfunction

    task automatic usb(input logic [7:0] d);
        usb_gamepad_data = d;
        usb_gamepad_ena = 1'b1;
        tick();
        usb_gamepad_ena = 1'b0;
    endtask

    task automatic wr(input logic b);
        jp_wr = 1'b1;
        jp_wdata = b;
        tick();
        jp_wr = 1'b0;
    endtask

    task automatic push_e(input logic em, input logic en);
        exp_q.push_back({en, em});
    endtask

    task automatic push_report(input logic [7:0] d, input int n);
        logic [7:0] m;
        m = model_mask(d);
        for (int i = 0; i < n; i++)
            push_e(i < 8 ? m[i] : 1'b1, i < 8 ? d[i] : 1'b1);
    endtask

    task automatic do_reads(input int n);
        logic [1:0] e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 8'd1, 8'd0);
                e = 2'b11;
            end else e = exp_q.pop_front();
            chk($sformatf("rd_m%0d", i), {7'd0, dout_m}, {7'd0, e[0]});
            chk($sformatf("rd_n%0d", i), {7'd0, dout_n}, {7'd0, e[1]});
            jp_rd = 1'b1;
            tick();
            jp_rd = 1'b0;
        end
    endtask

    initial begin
        tick();
        chk("rst_dout", {6'd0, dout_n, dout_m}, 8'h03);
        chk("rst_pc", {6'd0, pc_n, pc_m}, 8'h00);
        rst = 1'b1;
        tick();
        push_e(1'b1, 1'b1);
        do_reads(1);

        // A+Start, ten reads with the trailing ones
        usb(8'h09);
        chk("pc_up", {6'd0, pc_n, pc_m}, 8'h03);
        wr(1'b1);
        wr(1'b0);
        push_report(8'h09, 10);
        do_reads(10);

        // Up+Down suppressed only on the masked port
        usb(8'h30);
        wr(1'b1);
        wr(1'b0);
        push_report(8'h30, 8);
        do_reads(8);

        // strobe held: reads return A without shifting
        usb(8'h01);
        wr(1'b1);
        for (int i = 0; i < 3; i++) push_e(1'b1, 1'b1);
        do_reads(3);
        wr(1'b0);
        push_report(8'h01, 2);
        do_reads(2);

        // strobe release coincident with a read does not shift
        usb(8'h81);
        wr(1'b1);
        jp_wr = 1'b1;
        jp_wdata = 1'b0;
        jp_rd = 1'b1;
        tick();
        jp_wr = 1'b0;
        jp_rd = 1'b0;
        push_report(8'h81, 9);
        do_reads(9);

        // report arriving during strobe is seen one cycle later
        usb(8'h00);
        jp_wr = 1'b1;
        jp_wdata = 1'b1;
        tick();
        jp_wr = 1'b0;
        usb(8'h01);
        chk("ena_in_load", {6'd0, dout_n, dout_m}, 8'h03);
        wr(1'b0);
        push_report(8'h01, 3);
        do_reads(3);

        // reset mid-sequence abandons it
        usb(8'h0E);
        wr(1'b1);
        wr(1'b0);
        push_report(8'h0E, 3);
        do_reads(3);
        rst = 1'b0;
        tick();
        chk("mid_rst_pc", {6'd0, pc_n, pc_m}, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) push_e(1'b1, 1'b1);
        do_reads(5);

        // timeout drops the pad and clears buttons
        usb(8'hFF);
        for (int i = 0; i < 300 && pc_m; i++) tick();
        chk("to_drop", {6'd0, pc_n, pc_m}, 8'h00);
        wr(1'b1);
        wr(1'b0);
        push_report(8'h00, 8);
        do_reads(8);
        usb(8'h02);
        chk("to_reconn", {6'd0, pc_n, pc_m}, 8'h03);
        wr(1'b1);
        wr(1'b0);
        push_report(8'h02, 8);
        do_reads(8);

        chk("sb_drain", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nes_joypad_port.md
NES_JOYPAD_PORT -- requirements
Module: nes_joypad_port

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2400000, SHALL set the cycles without usb_gamepad_ena before the pad is declared disconnected (100 ms at 24 MHz).
REQ-002 Parameter MASK_OPPOSING, default 1, SHALL enable suppression of simultaneous Up+Down and Left+Right.
REQ-003 clk24  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 usb_gamepad_ena  input  1  one-cycle pulse; usb_gamepad_data is valid.
REQ-006 usb_gamepad_data  input  8  button report, 1 = pressed; bit0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-007 jp_wr  input  1  one-cycle pulse; CPU write to $4016.
REQ-008 jp_wdata  input  1  bit0 of the CPU write (strobe value).
REQ-009 jp_rd  input  1  one-cycle pulse; CPU read of $4016, port 1.
REQ-010 jp_dout  output  1  serial button bit returned to the CPU, 1 = pressed.
REQ-011 pad_connected  output  1  high while USB reports arrive within TIMEOUT_CYCLES.

Function
REQ-012 On usb_gamepad_ena, the block SHALL capture usb_gamepad_data into latch_q at that clock edge; the new value is visible to loads from the next cycle.
REQ-013 With MASK_OPPOSING=1, a captured report with bits 4 and 5 both set SHALL store both as 0; bits 6 and 7 likewise.
REQ-014 jp_wr SHALL update strobe_q <= jp_wdata; other writes SHALL be ignored.
REQ-015 The FSM SHALL have states LOAD, SHIFT, DONE.
REQ-016 LOAD (strobe_q=1): shreg SHALL reload from latch_q every cycle, bit counter = 0, and jp_rd SHALL NOT shift.
REQ-017 LOAD -> SHIFT on the cycle strobe_q falls; shreg keeps the last loaded value.
REQ-018 SHIFT: each jp_rd SHALL shift shreg right, fill the MSB with 1, and increment the counter; SHIFT -> DONE when the counter reaches 8.
REQ-019 DONE: the counter SHALL saturate at 8, and jp_rd SHALL leave shreg at 8'hFF.
REQ-020 Any state -> LOAD when strobe_q becomes 1.
REQ-021 jp_dout SHALL equal latch_q[0] in LOAD and shreg[0] otherwise, combinationally from registers; a read sampled in the jp_rd cycle returns the pre-shift bit.
REQ-022 When jp_wr and jp_rd occur in the same cycle, the write SHALL take effect and the read SHALL NOT shift.
REQ-023 A 24-bit timeout counter SHALL clear on usb_gamepad_ena and otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-024 At saturation, pad_connected SHALL drop and latch_q SHALL clear to 0.
REQ-025 The next usb_gamepad_ena SHALL set pad_connected=1 and capture normally.
REQ-026 usb_gamepad_ena coincident with a LOAD-state reload SHALL load the old latch_q that cycle and the new value on the following cycle.

Reset
REQ-027 Reset SHALL clear latch_q and strobe_q to 0, set shreg=8'hFF, counter=8 and state=DONE, clear the timeout counter, and drive pad_connected=0; jp_dout SHALL therefore be 1.
REQ-028 Reset asserted mid-read sequence SHALL abandon the sequence; after release, reads SHALL return 1 until the next strobe.

Structure
REQ-029 The FSM state encoding, button bit-index constants (BTN_A..BTN_RIGHT) and TIMEOUT default SHALL live in shared package nes_input_pkg.
REQ-030 The timeout counter SHALL be a sub-module, nes_pad_watchdog (inputs: clear pulse; output: expired).
REQ-031 The block SHALL use no other sub-modules and no second clock.

Verification
REQ-032 Report 8'h09 (A+Start), strobe 1 then 0, 10 reads -> jp_dout sequence 1,0,0,1,0,0,0,0,1,1.
REQ-033 Report 8'h30 (Up+Down) with MASK_OPPOSING=1 -> 8 reads all 0; with MASK_OPPOSING=0 -> bits 4 and 5 read as 1.
REQ-034 Strobe held at 1 with report 8'h01, 3 reads -> jp_dout=1 each read, no shift; strobe 0 -> the 2nd read returns 0.
REQ-035 Report 8'hFF, then no ena for TIMEOUT_CYCLES (bench override 100) -> pad_connected=0 and a strobe/read yields all 0; next ena 8'h02 -> pad_connected=1 and read 2 =1.
REQ-036 jp_wr(0) coincident with jp_rd after strobe -> no shift, and the first read returns A.
REQ-037 Reset pulsed after 3 of 8 reads -> the following reads return 1 until a fresh strobe.
